// File: rtl/regfile_wr_arbiter.sv
// Two-requester writeback arbiter sharing the register file write port.
// Define REGFILE_ARB_RR_EN for round-robin; default is fixed priority (req0 first).
module regfile_wr_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic [ADDRESS_WIDTH-1:0]    req0_addr,
    input  logic [DATA_WIDTH-1:0]       req0_data,
    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic [ADDRESS_WIDTH-1:0]    req1_addr,
    input  logic [DATA_WIDTH-1:0]       req1_data,
    output logic                        we3,
    output logic [ADDRESS_WIDTH-1:0]    ad3,
    output logic [DATA_WIDTH-1:0]       wd3,
    output logic [2**ADDRESS_WIDTH-1:0] busy_mask
);

    localparam int IW   = $clog2(FIFO_DEPTH);
    localparam int PW   = IW + 1;
    localparam int NREG = 2 ** ADDRESS_WIDTH;

    logic [PW-1:0]            wr_q [2];
    logic [PW-1:0]            wr_d [2];
    logic [PW-1:0]            rd_q [2];
    logic [PW-1:0]            rd_d [2];
    logic [PW-1:0]            cnt  [2];
    logic [ADDRESS_WIDTH-1:0] mem_addr [2][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    mem_data [2][FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] in_addr [2];
    logic [DATA_WIDTH-1:0]    in_data [2];
    logic [1:0]               in_valid;
    logic [1:0]               empty;
    logic [1:0]               full;
    logic [1:0]               push;
    logic [1:0]               pop;
    logic                     rdy_q;
    logic                     gnt;
    logic                     pop_any;
    logic [ADDRESS_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0]    head_data;
    logic                     we3_q, we3_d;
    logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
    logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;
    logic [NREG-1:0]          busy_d;
    logic [IW-1:0]            off;

    assign in_valid   = {req1_valid, req0_valid};
    assign in_addr[0] = req0_addr;
    assign in_addr[1] = req1_addr;
    assign in_data[0] = req0_data;
    assign in_data[1] = req1_data;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            cnt[n]   = wr_q[n] - rd_q[n];
            empty[n] = (wr_q[n] == rd_q[n]);
            full[n]  = (wr_q[n][IW-1:0] == rd_q[n][IW-1:0]) &&
                       (wr_q[n][IW] != rd_q[n][IW]);
            push[n]  = in_valid[n] & rdy_q & ~full[n] & ~flush;
        end
    end

    assign req0_ready = rdy_q & ~full[0];
    assign req1_ready = rdy_q & ~full[1];

`ifdef REGFILE_ARB_RR_EN
    // rr_q names the requester preferred on the next contested cycle
    logic rr_q;

    always_comb begin
        gnt = empty[0];
        if (!empty[0] && !empty[1])
            gnt = rr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_q <= 1'b0;
        else if (pop_any)
            rr_q <= ~gnt;
    end
`else
    assign gnt = empty[0];
`endif

    assign pop_any   = ~flush & ~(&empty);
    assign pop       = pop_any ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign head_addr = mem_addr[gnt][rd_q[gnt][IW-1:0]];
    assign head_data = mem_data[gnt][rd_q[gnt][IW-1:0]];

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            wr_d[n] = wr_q[n];
            rd_d[n] = rd_q[n];
            if (push[n])
                wr_d[n] = wr_q[n] + PW'(1);
            if (pop[n])
                rd_d[n] = rd_q[n] + PW'(1);
            if (flush) begin
                wr_d[n] = '0;
                rd_d[n] = '0;
            end
        end
        we3_d = pop_any && (head_addr != '0);
        ad3_d = ad3_q;
        wd3_d = wd3_q;
        if (pop_any) begin
            ad3_d = head_addr;
            wd3_d = head_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                wr_q[n] <= '0;
                rd_q[n] <= '0;
            end
            rdy_q <= 1'b0;
            we3_q <= 1'b0;
            ad3_q <= '0;
            wd3_q <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                wr_q[n] <= wr_d[n];
                rd_q[n] <= rd_d[n];
            end
            rdy_q <= 1'b1;
            we3_q <= we3_d;
            ad3_q <= ad3_d;
            wd3_q <= wd3_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                mem_addr[n][wr_q[n][IW-1:0]] <= in_addr[n];
                mem_data[n][wr_q[n][IW-1:0]] <= in_data[n];
            end
        end
    end

    // Slot i is live when its distance from the read pointer is below the fill count
    always_comb begin
        busy_d = '0;
        off    = '0;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                off = IW'(i) - rd_q[n][IW-1:0];
                if (PW'(off) < cnt[n])
                    busy_d[mem_addr[n][i]] = 1'b1;
            end
        end
        if (we3_q)
            busy_d[ad3_q] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign we3       = we3_q;
    assign ad3       = ad3_q;
    assign wd3       = wd3_q;
    assign busy_mask = busy_d;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a small register file model.
// Expected orderings follow REGFILE_ARB_RR_EN when that macro is defined.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        we3;
    logic [4:0]  ad3;
    logic [31:0] wd3;
    logic [31:0] busy_mask;

    logic [31:0] rf [32];
    int          n7;
    int          n_err;
    int          n_chk;

    regfile_wr_arbiter #(
        .ADDRESS_WIDTH(5),
        .DATA_WIDTH   (32),
        .FIFO_DEPTH   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .we3       (we3),
        .ad3       (ad3),
        .wd3       (wd3),
        .busy_mask (busy_mask)
    );

    always #5 clk = ~clk;

    // Register file model: x0 is not hardwired so a stray x0 write shows up
    always @(posedge clk) begin
        if (we3)
            rf[ad3] <= wd3;
        if (we3 && ad3 == 5'd7)
            n7 <= n7 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] ord [4];
    int         base7;
    bit         done;

    initial begin
        n_err = 0;
        n_chk = 0;
        n7    = 0;
        for (int r = 0; r < 32; r++)
            rf[r] = '0;
        rst        = 1'b1;
        flush      = 1'b0;
        req0_valid = 1'b0;
        req0_addr  = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_addr  = '0;
        req1_data  = '0;

        #12;
        chk("rst_ready0", 64'(req0_ready), 64'd0);
        chk("rst_ready1", 64'(req1_ready), 64'd0);
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_ad3", 64'(ad3), 64'd0);
        chk("rst_wd3", 64'(wd3), 64'd0);
        chk("rst_busy", 64'(busy_mask), 64'd0);
        rst = 1'b0;
        step();
        chk("ready0_up", 64'(req0_ready), 64'd1);
        chk("ready1_up", 64'(req1_ready), 64'd1);

        // single write to x5
        req0_valid = 1'b1;
        req0_addr  = 5'd5;
        req0_data  = 32'hDEADBEEF;
        step();
        req0_valid = 1'b0;
        chk("w5_busy_e0", 64'(busy_mask), 64'h20);
        chk("w5_we3_e0", 64'(we3), 64'd0);
        step();
        chk("w5_we3", 64'(we3), 64'd1);
        chk("w5_ad3", 64'(ad3), 64'd5);
        chk("w5_wd3", 64'(wd3), 64'hDEADBEEF);
        chk("w5_busy_e1", 64'(busy_mask), 64'h20);
        step();
        chk("w5_we3_off", 64'(we3), 64'd0);
        chk("w5_busy_clr", 64'(busy_mask), 64'd0);
        chk("w5_rf", 64'(rf[5]), 64'hDEADBEEF);

        // two entries from each requester in the same cycles
`ifdef REGFILE_ARB_RR_EN
        ord[0] = 5'd1; ord[1] = 5'd3; ord[2] = 5'd2; ord[3] = 5'd4;
`else
        ord[0] = 5'd1; ord[1] = 5'd2; ord[2] = 5'd3; ord[3] = 5'd4;
`endif
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h33;
        step();
        chk("ord_busy", 64'(busy_mask), 64'h0A);
        req0_addr = 5'd2; req0_data = 32'h22;
        req1_addr = 5'd4; req1_data = 32'h44;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ord%0d_we3", k), 64'(we3), 64'd1);
            chk($sformatf("ord%0d_ad3", k), 64'(ad3), 64'(ord[k]));
            step();
        end
        chk("ord_idle", 64'(we3), 64'd0);
        chk("ord_busy_clr", 64'(busy_mask), 64'd0);
        chk("ord_rf3", 64'(rf[3]), 64'h33);

        // req0 streams while req1 holds valid with changing payload
        base7      = n7;
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66;
        req1_valid = 1'b1; req1_addr = 5'd7;
        for (int i = 0; i < 8; i++) begin
            req1_data = 32'(i);
            step();
`ifndef REGFILE_ARB_RR_EN
            if (i >= 1)
                chk($sformatf("starve_rdy%0d", i), 64'(req1_ready), 64'd0);
`endif
        end
`ifdef REGFILE_ARB_RR_EN
        chk("rr_req1_served", 64'(n7 > base7), 64'd1);
`else
        chk("starve_none", 64'(n7 - base7), 64'd0);
`endif
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            step();
            done = (we3 == 1'b0) && (busy_mask == '0);
        end
        chk("drain_done", 64'(done), 64'd1);
`ifndef REGFILE_ARB_RR_EN
        chk("starve_cap2", 64'(n7 - base7), 64'd2);
        chk("starve_rf7", 64'(rf[7]), 64'd1);
`endif

        // write to x0
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h1234;
        step();
        req0_valid = 1'b0;
        chk("x0_busy_e0", 64'(busy_mask), 64'd0);
        step();
        chk("x0_we3", 64'(we3), 64'd0);
        chk("x0_busy_e1", 64'(busy_mask), 64'd0);
        step();
        chk("x0_rf", 64'(rf[0]), 64'd0);

        // flush with one staged write and two queued
        req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'hA8;
        step();
        req0_addr = 5'd9; req0_data = 32'hA9;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'hAA;
        step();
        chk("fl_stage_we3", 64'(we3), 64'd1);
        chk("fl_stage_ad3", 64'(ad3), 64'd8);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_we3", 64'(we3), 64'd0);
        chk("fl_busy", 64'(busy_mask), 64'd0);
        chk("fl_rdy0", 64'(req0_ready), 64'd1);
        chk("fl_rdy1", 64'(req1_ready), 64'd1);
        chk("fl_rf8", 64'(rf[8]), 64'hA8);
        step();
        chk("fl_we3_after", 64'(we3), 64'd0);
        chk("fl_rf9", 64'(rf[9]), 64'd0);
        chk("fl_rf10", 64'(rf[10]), 64'd0);

        // asynchronous reset mid-stream
        req0_valid = 1'b1; req0_addr = 5'd11; req0_data = 32'hB1;
        step();
        req0_addr = 5'd12; req0_data = 32'hB2;
        step();
        req0_valid = 1'b0;
        chk("ar_pre_we3", 64'(we3), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_we3", 64'(we3), 64'd0);
        chk("ar_busy", 64'(busy_mask), 64'd0);
        chk("ar_rdy0", 64'(req0_ready), 64'd0);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ar_idle%0d", k), 64'(we3), 64'd0);
            chk($sformatf("ar_busy%0d", k), 64'(busy_mask), 64'd0);
        end
        chk("ar_rdy0_up", 64'(req0_ready), 64'd1);
        chk("ar_rf11", 64'(rf[11]), 64'd0);
        chk("ar_rf12", 64'(rf[12]), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port (WE3/AD3/WD3) between two writeback requesters: req0 (ALU/execute) and req1 (load/multicycle unit).
- Each requester has a small FIFO. An arbiter pops one entry per cycle into a registered write stage that drives the register file.
- Exports a per-register pending-write mask so the issue logic can stall reads of registers with writes still in flight.

Parameters:
- ADDRESS_WIDTH, 5: register address width (2**ADDRESS_WIDTH registers).
- DATA_WIDTH, 32: register data width.
- FIFO_DEPTH, 2: entries per requester FIFO; power of two, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all queued and staged writes.
- req0_valid  input  1  requester 0 has a write.
- req0_ready  output  1  requester 0 FIFO can accept.
- req0_addr  input  ADDRESS_WIDTH  destination register.
- req0_data  input  DATA_WIDTH  write data.
- req1_valid / req1_ready / req1_addr / req1_data: same as req0, for requester 1.
- we3  output  1  register file write enable.
- ad3  output  ADDRESS_WIDTH  register file write address.
- wd3  output  DATA_WIDTH  register file write data.
- busy_mask  output  2**ADDRESS_WIDTH  bit i = 1 while a write to register i is queued or staged.

Behaviour:
- Reset (async, rst=1):
  - Both FIFOs empty, RR pointer = 0.
  - we3=0, ad3=0, wd3=0, busy_mask=0.
  - req0_ready=0 and req1_ready=0 while rst=1; both go to 1 in the first cycle after deassertion.
- Accept:
  - A transfer occurs on the rising edge when reqN_valid & reqN_ready.
  - reqN_ready = !fifoN_full. It is independent of reqN_valid and of a same-cycle pop (no push-through when full).
  - A requester may hold valid with changing payload while ready=0; nothing is captured until ready=1.
- Arbitration (each cycle, on the FIFO heads):
  - Candidates are non-empty FIFOs. Without flush, exactly one head is popped per cycle if any FIFO is non-empty.
  - Winner selection: fixed priority, req0 over req1 (see Optional Feature).
  - The popped entry loads the write stage: we3 <= 1, ad3 <= addr, wd3 <= data.
  - When nothing is popped: we3 <= 0; ad3 and wd3 hold their previous values.
- Latency:
  - Entry accepted at edge E0 → popped at E1 at the earliest → we3 high in the cycle after E1 → register file updated at E2.
  - Sustained throughput is one write per cycle total.
- Register x0:
  - An entry with addr == 0 is accepted and popped normally but loads we3 <= 0.
  - x0 never sets a busy_mask bit; busy_mask[0] is always 0.
- busy_mask:
  - Combinational OR over all valid FIFO entries of both requesters plus the write stage when we3=1.
  - A bit clears in the cycle after the last pending write to that register has been presented with we3=1.
- Ordering:
  - Per-requester order is preserved.
  - Between requesters, order follows arbitration. Same-register writes from both queues are issue-logic's responsibility, via busy_mask stall.
- Flush (synchronous, takes effect at the edge where flush=1):
  - FIFOs empty, we3 <= 0, no push accepted that cycle, RR pointer unchanged.
  - If flush=1 and a stage write with we3=1 is already presented that cycle, that write still commits at the same edge.
- Reset mid-operation:
  - All queued writes are lost; we3 drops immediately (async).
- Pointer widths: FIFO pointers are clog2(FIFO_DEPTH)+1 bits with a wrap bit; full and empty are derived from pointer compare.

Optional Feature:
- Macro: REGFILE_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. When both FIFOs are non-empty, the requester not granted last is granted.
  - A 1-bit last-grant register updates only on a pop; its reset value makes req0 win the first contested cycle.
- Undefined:
  - Fixed priority, req0 over req1. req1 can starve under sustained req0 traffic.

Test Plan:
- Reset, then req0 write addr=5 data=0xDEADBEEF at edge E0 → we3=1, ad3=5, wd3=0xDEADBEEF in the cycle after E1. busy_mask[5]=1 from E0 until we3 drops. Read of x5 after E2 = 0xDEADBEEF.
- Both requesters push 2 entries each in the same cycles (req0 addr 1,2; req1 addr 3,4):
  - Fixed priority → ad3 order 1,2,3,4.
  - With REGFILE_ARB_RR_EN → ad3 order 1,3,2,4.
- req1 holds valid with FIFO_DEPTH entries queued while req0 streams → req1_ready=0 with no capture. Under fixed priority req1 is starved until req0 idles; with REGFILE_ARB_RR_EN req1 is granted every other cycle.
- Write addr=0 data=0x1234 → popped with we3=0; busy_mask stays 0; x0 reads 0.
- Queue 3 writes, assert flush for one cycle → we3=0 next cycle, busy_mask=0, both readys=1. The write staged in the flush cycle still commits.
- Assert rst asynchronously mid-stream between clock edges → we3=0 and busy_mask=0 immediately. No writes occur after deassertion until new requests arrive.
